// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage access unit: region codes, access sizes,
// IO load FSM states and the posted IO store entry.
package mem_access_unit_pkg;

  localparam logic [3:0] REGION_DMEM   = 4'h1;
  localparam logic [3:0] REGION_IMEM   = 4'h2;
  localparam logic [3:0] REGION_MIRROR = 4'h3;
  localparam logic [3:0] REGION_BIOS   = 4'h4;
  localparam logic [3:0] REGION_IO     = 4'h8;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct3[1:0] of loads and stores
  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'b00,
    MEM_SIZE_H = 2'b01,
    MEM_SIZE_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IO_IDLE,
    IO_DRAIN,
    IO_READ
  } io_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstrb;
  } store_entry_t;

endpackage

// File: rtl/mem_access_unit_io_store_fifo.sv
// io_store_fifo: posted IO store buffer, registered push, head visible next cycle.
// Push at full is accepted only alongside a pop; pop on empty is ignored.
module io_store_fifo
  import mem_access_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  store_entry_t push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output store_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  store_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage region decode, store strobes/forwarding, posted IO stores, IO load FSM.
// Decode is combinational; IO loads stall until their read handshake, full buffer stalls stores. Option: MEM_MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int IO_BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] rs2_data,
  input  logic [31:0] wb_inst,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        bios_en,
  output logic        dmem_en,
  output logic [3:0]  dmem_we,
  output logic [3:0]  imem_we,
  output logic [31:0] mem_wdata,
  output logic        io_req,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_wstrb,
  input  logic        io_ready,
  input  logic [31:0] io_rdata,
  output logic [31:0] io_load_data,
  output logic        misalign
);

  logic         is_load, is_store, is_mem;
  mem_size_e    size;
  logic [3:0]   region;
  logic         wb_writes_rd, fwd_sel;
  logic [31:0]  st_src, st_lane;
  logic [3:0]   st_strb;
  logic         mis, go;
  logic         io_ld, io_st;
  logic         fifo_push, fifo_full, fifo_empty, head_vld, pop;
  store_entry_t fifo_head, fifo_in;
  io_state_e    state, state_nxt;
  logic         unused_bits;

  assign is_load  = (inst[6:0] == OPC_LOAD);
  assign is_store = (inst[6:0] == OPC_STORE);
  assign is_mem   = is_load || is_store;
  assign size     = mem_size_e'(inst[13:12]);
  assign region   = addr[31:28];

  // x0 never forwards; stores, branches and CSR ops leave rd unwritten
  assign wb_writes_rd = !(wb_inst[6:0] inside {OPC_STORE, OPC_BRANCH, OPC_SYSTEM});
  assign fwd_sel      = (inst[24:20] != 5'd0) && wb_writes_rd && (wb_inst[11:7] == inst[24:20]);
  assign st_src       = fwd_sel ? wb_data : rs2_data;

  always_comb begin
    st_strb = 4'b0000;
    st_lane = st_src;
    case (size)
      MEM_SIZE_B: begin
        st_strb = 4'b0001 << addr[1:0];
        st_lane = {4{st_src[7:0]}};
      end
      MEM_SIZE_H: begin
        st_strb = 4'b0011 << {addr[1], 1'b0};
        st_lane = {2{st_src[15:0]}};
      end
      MEM_SIZE_W: st_strb = 4'b1111;
      default:    st_strb = 4'b0000;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = valid && is_mem &&
               (((size == MEM_SIZE_H) && addr[0]) || ((size == MEM_SIZE_W) && (addr[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  assign go        = valid && !stall && !mis && !rst;
  assign bios_en   = go && is_load && (region == REGION_BIOS);
  assign dmem_en   = go && is_mem && ((region == REGION_DMEM) || (region == REGION_MIRROR));
  assign dmem_we   = (go && is_store && ((region == REGION_DMEM) || (region == REGION_MIRROR)))
                     ? st_strb : 4'b0000;
  assign imem_we   = (go && is_store && pc[30] && ((region == REGION_IMEM) || (region == REGION_MIRROR)))
                     ? st_strb : 4'b0000;
  assign mem_wdata = rst ? 32'd0 : st_lane;
  assign misalign  = mis && !rst;

  assign io_ld     = valid && is_load  && (region == REGION_IO) && !mis;
  assign io_st     = valid && is_store && (region == REGION_IO) && !mis;
  assign fifo_push = go && is_store && (region == REGION_IO);
  assign fifo_in   = '{addr: addr, data: st_lane, wstrb: st_strb};

  // buffered stores drain in IDLE and DRAIN; READ owns the IO port
  assign head_vld  = !fifo_empty && (state != IO_READ);
  assign pop       = head_vld && io_ready;

  io_store_fifo #(.DEPTH(IO_BUF_DEPTH)) u_io_store_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (fifo_in),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IO_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    io_req    = 1'b0;
    io_we     = 1'b0;
    io_addr   = 32'd0;
    io_wdata  = 32'd0;
    io_wstrb  = 4'b0000;
    case (state)
      IO_IDLE: begin
        // hold the load in MEM from the first cycle it is seen
        if (io_ld) begin
          stall     = 1'b1;
          state_nxt = fifo_empty ? IO_READ : IO_DRAIN;
        end
      end
      IO_DRAIN: begin
        stall = 1'b1;
        if (fifo_empty) state_nxt = IO_READ;
      end
      IO_READ: begin
        io_req  = 1'b1;
        io_addr = addr;
        stall   = !io_ready;
        if (io_ready) state_nxt = IO_IDLE;
      end
      default: state_nxt = IO_IDLE;
    endcase
    if (head_vld) begin
      io_req   = 1'b1;
      io_we    = 1'b1;
      io_addr  = fifo_head.addr;
      io_wdata = fifo_head.data;
      io_wstrb = fifo_head.wstrb;
    end
    if (io_st && fifo_full && !pop) stall = 1'b1;
    if (rst) begin
      stall    = 1'b0;
      io_req   = 1'b0;
      io_we    = 1'b0;
      io_addr  = 32'd0;
      io_wdata = 32'd0;
      io_wstrb = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                              io_load_data <= 32'd0;
    else if (state == IO_READ && io_ready) io_load_data <= io_rdata;
  end

  assign unused_bits = ^{inst, pc, wb_inst};

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstrb;
  } exp_wr_t;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, valid, io_ready;
  logic [31:0] inst, pc, addr, rs2_data, wb_inst, wb_data, io_rdata;
  logic        stall, bios_en, dmem_en, io_req, io_we, misalign;
  logic [3:0]  dmem_we, imem_we, io_wstrb;
  logic [31:0] mem_wdata, io_addr, io_wdata, io_load_data;

  int      n_cmp = 0;
  int      n_err = 0;
  int      n_wr  = 0;
  exp_wr_t exp_q[$];
  exp_wr_t mon_e;

  logic [2:0]  st_f3   [5];
  logic [31:0] st_addr [5];
  logic [31:0] st_rs2  [5];
  logic [31:0] ex_data [5];
  logic [3:0]  ex_strb [5];

  always #5 clk = ~clk;

  mem_access_unit #(.IO_BUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .valid(valid), .inst(inst), .pc(pc), .addr(addr),
    .rs2_data(rs2_data), .wb_inst(wb_inst), .wb_data(wb_data), .stall(stall),
    .bios_en(bios_en), .dmem_en(dmem_en), .dmem_we(dmem_we), .imem_we(imem_we),
    .mem_wdata(mem_wdata), .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_wstrb(io_wstrb), .io_ready(io_ready), .io_rdata(io_rdata),
    .io_load_data(io_load_data), .misalign(misalign)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] d);
    valid    = v;
    inst     = i;
    addr     = a;
    rs2_data = d;
  endtask

  function automatic logic [31:0] enc_store(input logic [2:0] f3, input logic [4:0] rs2);
    return {7'd0, rs2, 5'd1, f3, 5'd0, 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_load(input logic [2:0] f3, input logic [4:0] rd);
    return {12'd0, 5'd1, f3, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  // IO write scoreboard: every accepted write handshake must match the oldest expected store
  always @(negedge clk) begin
    if (!rst && io_req && io_we && io_ready) begin
      n_wr++;
      check("io_wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("io_wr_addr", io_addr, mon_e.addr);
        check("io_wr_data", io_wdata, mon_e.data);
        check("io_wr_strb", 32'(io_wstrb), 32'(mon_e.wstrb));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  wr0;
    bit  done;
    st_f3[0] = 3'b010; st_addr[0] = 32'h8000_0000; st_rs2[0] = 32'h1111_0000; ex_data[0] = 32'h1111_0000; ex_strb[0] = 4'b1111;
    st_f3[1] = 3'b000; st_addr[1] = 32'h8000_0101; st_rs2[1] = 32'h0000_00C3; ex_data[1] = 32'hC3C3_C3C3; ex_strb[1] = 4'b0010;
    st_f3[2] = 3'b001; st_addr[2] = 32'h8000_0202; st_rs2[2] = 32'h1234_BEEF; ex_data[2] = 32'hBEEF_BEEF; ex_strb[2] = 4'b1100;
    st_f3[3] = 3'b010; st_addr[3] = 32'h8000_0300; st_rs2[3] = 32'h3333_3333; ex_data[3] = 32'h3333_3333; ex_strb[3] = 4'b1111;
    st_f3[4] = 3'b010; st_addr[4] = 32'h8000_0400; st_rs2[4] = 32'h4444_4444; ex_data[4] = 32'h4444_4444; ex_strb[4] = 4'b1111;

    rst = 1'b1; valid = 1'b0; inst = 32'h13; pc = 32'h0; addr = 32'h0; rs2_data = 32'h0;
    wb_inst = 32'h13; wb_data = 32'h0; io_ready = 1'b0; io_rdata = 32'h0;

    // reset with a live DMEM store on the inputs
    cyc();
    drive(1'b1, enc_store(3'b010, 5'd3), 32'h1000_0000, 32'hFFFF_FFFF);
    settle();
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_dmem_en", 32'(dmem_en), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_io_req", 32'(io_req), 32'd0);
    check("rst_io_load_data", io_load_data, 32'd0);

    cyc();
    rst = 1'b0;
    drive(1'b0, 32'h13, 32'h0, 32'h0);

    // SB x5 -> 0x1000_0003
    cyc();
    drive(1'b1, enc_store(3'b000, 5'd5), 32'h1000_0003, 32'h0000_00AB);
    settle();
    check("sb_dmem_we", 32'(dmem_we), 32'h8);
    check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    check("sb_dmem_en", 32'(dmem_en), 32'd1);
    check("sb_imem_we", 32'(imem_we), 32'd0);

    // SW to IMEM, from BIOS pc then from ordinary pc
    cyc();
    pc = 32'h4000_0000;
    drive(1'b1, enc_store(3'b010, 5'd6), 32'h2000_0000, 32'h1234_5678);
    settle();
    check("sw_imem_we_bios", 32'(imem_we), 32'hF);
    check("sw_imem_dmem_we", 32'(dmem_we), 32'd0);
    check("sw_imem_wdata", mem_wdata, 32'h1234_5678);
    cyc();
    pc = 32'h0000_1000;
    settle();
    check("sw_imem_we_user", 32'(imem_we), 32'd0);

    // SH to mirror region from BIOS pc writes both memories
    cyc();
    pc = 32'h4000_0000;
    drive(1'b1, enc_store(3'b001, 5'd6), 32'h3000_0002, 32'h0000_BEEF);
    settle();
    check("sh_mirror_dmem_we", 32'(dmem_we), 32'hC);
    check("sh_mirror_imem_we", 32'(imem_we), 32'hC);
    check("sh_mirror_wdata", mem_wdata, 32'hBEEF_BEEF);
    pc = 32'h0000_1000;

    // forwarding from WB
    cyc();
    wb_inst = enc_addi(5'd7, 12'h055); wb_data = 32'h55;
    drive(1'b1, enc_store(3'b010, 5'd7), 32'h1000_0000, 32'hFFFF_FFFF);
    settle();
    check("fwd_x7", mem_wdata, 32'h0000_0055);
    cyc();
    wb_inst = enc_addi(5'd0, 12'h055);
    drive(1'b1, enc_store(3'b010, 5'd0), 32'h1000_0000, 32'h0000_0000);
    settle();
    check("fwd_x0", mem_wdata, 32'h0000_0000);
    cyc();
    wb_inst = enc_store(3'b010, 5'd2) | 32'h0000_0380;
    drive(1'b1, enc_store(3'b010, 5'd7), 32'h1000_0000, 32'h0BAD_F00D);
    settle();
    check("fwd_wb_store", mem_wdata, 32'h0BAD_F00D);
    wb_inst = 32'h13; wb_data = 32'h0;

    // BIOS load and a bubble
    cyc();
    drive(1'b1, enc_load(3'b010, 5'd4), 32'h4000_0010, 32'h0);
    settle();
    check("bios_ld_bios_en", 32'(bios_en), 32'd1);
    check("bios_ld_dmem_en", 32'(dmem_en), 32'd0);
    cyc();
    drive(1'b0, enc_store(3'b010, 5'd3), 32'h1000_0000, 32'h1);
    settle();
    check("bubble_dmem_we", 32'(dmem_we), 32'd0);
    check("bubble_dmem_en", 32'(dmem_en), 32'd0);

    // fill the IO buffer with io_ready low
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(1'b1, enc_store(st_f3[i], 5'd9), st_addr[i], st_rs2[i]);
      settle();
      check("fill_stall", 32'(stall), 32'd0);
      exp_q.push_back('{addr: st_addr[i], data: ex_data[i], wstrb: ex_strb[i]});
    end
    cyc();
    drive(1'b1, enc_store(st_f3[4], 5'd9), st_addr[4], st_rs2[4]);
    settle();
    check("full_stall", 32'(stall), 32'd1);
    cyc();
    settle();
    check("full_stall_hold", 32'(stall), 32'd1);
    check("full_head_addr", io_addr, st_addr[0]);
    check("full_head_we", 32'(io_we), 32'd1);
    cyc();
    io_ready = 1'b1;
    settle();
    check("full_pop_stall", 32'(stall), 32'd0);
    exp_q.push_back('{addr: st_addr[4], data: ex_data[4], wstrb: ex_strb[4]});
    for (int i = 0; i < 6; i++) begin
      cyc();
      drive(1'b0, 32'h13, 32'h0, 32'h0);
    end
    settle();
    check("drain_q_empty", 32'(exp_q.size()), 32'd0);
    check("drain_io_req", 32'(io_req), 32'd0);

    // IO load behind two buffered stores
    io_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      drive(1'b1, enc_store(st_f3[i], 5'd9), st_addr[i], st_rs2[i]);
      exp_q.push_back('{addr: st_addr[i], data: ex_data[i], wstrb: ex_strb[i]});
    end
    cyc();
    drive(1'b1, enc_load(3'b010, 5'd10), 32'h8000_0040, 32'h0);
    settle();
    check("ld_first_stall", 32'(stall), 32'd1);
    cyc();
    settle();
    check("ld_drain_stall", 32'(stall), 32'd1);
    check("ld_drain_we", 32'(io_we), 32'd1);
    wr0  = n_wr;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      cyc();
      io_ready = 1'b1;
      io_rdata = 32'hDEAD_BEEF;
      settle();
      if (io_req && !io_we) begin
        done = 1'b1;
        check("rd_stall", 32'(stall), 32'd0);
        check("rd_addr", io_addr, 32'h8000_0040);
        check("rd_wstrb", 32'(io_wstrb), 32'd0);
        check("rd_after_drains", 32'(n_wr - wr0), 32'd2);
        check("rd_q_empty", 32'(exp_q.size()), 32'd0);
      end else begin
        check("ld_wait_stall", 32'(stall), 32'd1);
      end
    end
    check("rd_timeout", 32'(done), 32'd1);
    cyc();
    io_ready = 1'b0;
    io_rdata = 32'h0;
    drive(1'b0, 32'h13, 32'h0, 32'h0);
    settle();
    check("ld_data_wb", io_load_data, 32'hDEAD_BEEF);
    cyc();
    drive(1'b1, enc_load(3'b010, 5'd4), 32'h1000_0000, 32'h0);
    settle();
    check("ld_data_hold", io_load_data, 32'hDEAD_BEEF);
    check("dmem_ld_stall", 32'(stall), 32'd0);

    // misaligned accesses
    cyc();
    drive(1'b1, enc_load(3'b010, 5'd4), 32'h1000_0002, 32'h0);
    settle();
    check("lw_mis_flag", 32'(misalign), 32'(TRAP));
    check("lw_mis_dmem_en", 32'(dmem_en), 32'(!TRAP));
    cyc();
    drive(1'b1, enc_store(3'b001, 5'd6), 32'h1000_0001, 32'h0000_BEEF);
    settle();
    check("sh_mis_dmem_we", 32'(dmem_we), TRAP ? 32'd0 : 32'h3);

    // reset during READ
    cyc();
    drive(1'b1, enc_load(3'b010, 5'd10), 32'h8000_0080, 32'h0);
    settle();
    check("rr_idle_stall", 32'(stall), 32'd1);
    cyc();
    settle();
    check("rr_read_req", 32'(io_req), 32'd1);
    check("rr_read_we", 32'(io_we), 32'd0);
    check("rr_read_addr", io_addr, 32'h8000_0080);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive(1'b0, 32'h13, 32'h0, 32'h0);
    settle();
    check("rr_io_req", 32'(io_req), 32'd0);
    check("rr_stall", 32'(stall), 32'd0);
    check("rr_load_data", io_load_data, 32'd0);
    cyc();
    settle();
    check("rr_idle_io_req", 32'(io_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
